// File: rtl/vga_fetch_pkg.sv
// Shared types and sizing helpers for the VGA line fetch controller.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fetch_state_e;

    localparam int H_RES_DFLT      = 640;
    localparam int BURST_DFLT      = 16;
    localparam int BURSTS_PER_LINE = H_RES_DFLT / BURST_DFLT;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Ping-pong line buffer: two halves of one display line each, one write port
// for the fetcher and one synchronous read port for the pixel pipeline.
module vga_line_ram #(
    parameter int DEPTH = 640,
    parameter int DATAW = 16,
    parameter int AW    = 10
) (
    input  logic             clk_pix,
    input  logic             wr_en,
    input  logic             wr_half,
    input  logic [AW-1:0]    wr_idx,
    input  logic [DATAW-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_half,
    input  logic [AW-1:0]    rd_idx,
    output logic [DATAW-1:0] rd_q
);

    logic [DATAW-1:0] mem [2][DEPTH];

    always_ff @(posedge clk_pix) begin
        if (wr_en) mem[wr_half][wr_idx] <= wr_data;
        if (rd_en) rd_q <= mem[rd_half][rd_idx];
    end

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Prefetches the next display line from the framebuffer in fixed bursts into a
// ping-pong buffer while the current line is replayed to the pixel pipeline.
module vga_line_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int          CORDW   = 16,
    parameter int          H_RES   = H_RES_DFLT,
    parameter int          V_RES   = 480,
    parameter int          ADDRW   = 24,
    parameter int          DATAW   = 16,
    parameter int          BURST   = BURST_DFLT,
    parameter int unsigned FB_BASE = 0
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de,
    output logic                    rd_req,
    output logic [ADDRW-1:0]        rd_addr,
    input  logic                    rd_gnt,
    input  logic                    rd_valid,
    input  logic [DATAW-1:0]        rd_data,
    output logic                    pix_de,
    output logic [DATAW-1:0]        pix_data,
    output logic                    busy,
    output logic                    underrun
);

    localparam int N_BURSTS = H_RES / BURST;
    localparam int BW       = cnt_w(N_BURSTS);
    localparam int WW       = cnt_w(BURST);
    localparam int IW       = cnt_w(H_RES);
    localparam logic signed [CORDW-1:0] SY_LAST = CORDW'(V_RES - 1);
    localparam logic [ADDRW-1:0]        BASE    = ADDRW'(FB_BASE);

    fetch_state_e     state_q, state_d;
    logic [BW-1:0]    b_q, b_d;
    logic [WW-1:0]    w_q, w_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             half_q, half_d;
    logic [ADDRW-1:0] line_addr_q, line_addr_d;
    logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
    logic             pend_q, pend_d;
    logic             pend_half_q, pend_half_d;
    logic [ADDRW-1:0] pend_addr_q, pend_addr_d;
    logic             pix_de_q, pix_de_d;

    logic             trig_line, trig, fetch, last_word, last_burst, done;
    logic             new_half, ld, ld_half, wr_en;
    logic [ADDRW-1:0] new_base, ld_addr;
    logic [DATAW-1:0] ram_q;

    // Frame restarts at the base; each line pulse walks one line forward.
    assign trig_line  = line && (sy < SY_LAST);
    assign trig       = frame || trig_line;
    assign fetch      = trig && en;
    assign new_base   = frame ? BASE : line_addr_q + ADDRW'(H_RES);
    assign new_half   = frame ? 1'b0 : ~sy[0];
    assign last_word  = (state_q == DATA) && rd_valid && (w_q == WW'(BURST - 1));
    assign last_burst = (b_q == BW'(N_BURSTS - 1));
    assign done       = last_word && last_burst;

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        w_d         = w_q;
        idx_d       = idx_q;
        half_d      = half_q;
        line_addr_d = line_addr_q;
        rd_addr_d   = rd_addr_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        pend_addr_d = pend_addr_q;
        pix_de_d    = de;
        underrun    = 1'b0;
        wr_en       = 1'b0;
        ld          = 1'b0;
        ld_half     = new_half;
        ld_addr     = new_base;

        if (trig) line_addr_d = new_base;

        // A trigger landing exactly on the final word is on time, not late.
        if (fetch && state_q != IDLE && !done) begin
            underrun    = 1'b1;
            pend_d      = 1'b1;
            pend_half_d = new_half;
            pend_addr_d = new_base;
        end

        case (state_q)
            IDLE: ld = fetch;
            REQ: begin
                if (rd_gnt) begin
                    state_d = DATA;
                    w_d     = '0;
                end else begin
                    ld = fetch;
                end
            end
            DATA: begin
                if (rd_valid) begin
                    wr_en = 1'b1;
                    w_d   = w_q + 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (last_word) begin
                        if (fetch) begin
                            ld = 1'b1;
                        end else if (pend_q) begin
                            ld      = 1'b1;
                            ld_half = pend_half_q;
                            ld_addr = pend_addr_q;
                        end else if (last_burst) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = REQ;
                            b_d       = b_q + 1'b1;
                            rd_addr_d = rd_addr_q + ADDRW'(BURST);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            state_d   = REQ;
            b_d       = '0;
            w_d       = '0;
            idx_d     = '0;
            half_d    = ld_half;
            rd_addr_d = ld_addr;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q     <= IDLE;
            b_q         <= '0;
            w_q         <= '0;
            idx_q       <= '0;
            half_q      <= 1'b0;
            line_addr_q <= BASE;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            pend_half_q <= 1'b0;
            pend_addr_q <= '0;
            pix_de_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            w_q         <= w_d;
            idx_q       <= idx_d;
            half_q      <= half_d;
            line_addr_q <= line_addr_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
            pend_addr_q <= pend_addr_d;
            pix_de_q    <= pix_de_d;
        end
    end

    assign rd_req   = (state_q == REQ);
    assign rd_addr  = rd_addr_q;
    assign busy     = (state_q != IDLE);
    assign pix_de   = pix_de_q;
    assign pix_data = pix_de_q ? ram_q : '0;

    logic unused_sx_hi;
    assign unused_sx_hi = ^sx[CORDW-1:IW];

    // Fetch half and display half always differ, so the ports never collide.
    vga_line_ram #(
        .DEPTH (H_RES),
        .DATAW (DATAW),
        .AW    (IW)
    ) u_ram (
        .clk_pix (clk_pix),
        .wr_en   (wr_en),
        .wr_half (half_q),
        .wr_idx  (idx_q),
        .wr_data (rd_data),
        .rd_en   (de),
        .rd_half (sy[0]),
        .rd_idx  (sx[IW-1:0]),
        .rd_q    (ram_q)
    );

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Scoreboard bench for vga_line_fetch_ctrl: a memory/arbiter model returns
// mem[a]=a, and a monitor checks grant addresses, pixels and underrun pulses.
module tb_vga_line_fetch_ctrl;

    localparam int H     = 640;
    localparam int BURST = 16;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic rst_m = 1'b1, rst_a = 1'b0, rst;
    logic en = 1'b0, frame = 1'b0, line_m = 1'b0, line_a = 1'b0, de = 1'b0;
    logic signed [15:0] sx = '0, sy = '0;
    logic rd_req, rd_gnt = 1'b0, rd_valid = 1'b0;
    logic [23:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic pix_de, busy, underrun;
    logic [15:0] pix_data;

    assign rst = rst_m | rst_a;

    vga_line_fetch_ctrl dut (
        .clk_pix  (clk_pix),
        .rst      (rst),
        .en       (en),
        .frame    (frame),
        .line     (line_m | line_a),
        .sx       (sx),
        .sy       (sy),
        .de       (de),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pix_de   (pix_de),
        .pix_data (pix_data),
        .busy     (busy),
        .underrun (underrun)
    );

    int vectors = 0, miscompares = 0;
    logic [23:0] exp_addr[$];
    logic [15:0] exp_pix[$];
    bit          exp_und[$];

    // Arbiter/memory model state
    int          gnt_delay = 3, wait_cnt = 0, words_left = 0, stray = 0, words_total = 0;
    logic [23:0] data_addr = '0;
    bit hold_gnt = 0, fire_on_last = 0, fired = 0, rst_on_word = 0, rst_fired = 0;

    initial forever begin
        @(posedge clk_pix); #1;
        rd_gnt = 0; rd_valid = 0; line_a = 0; rst_a = 0;
        if (rst_m) begin
            words_left = 0; wait_cnt = 0;
        end else if (stray > 0) begin
            rd_valid = 1; rd_data = 16'hBEEF; stray--;
        end else if (words_left > 0) begin
            if (rst_on_word && !rst_fired && words_left == BURST - 5) begin
                rst_a = 1; words_left = 0; stray = 5; rst_fired = 1;
            end else begin
                rd_valid = 1; rd_data = data_addr[15:0];
                if (fire_on_last && !fired && words_left == 1 && data_addr == 24'd639) begin
                    line_a = 1; fired = 1;
                end
                data_addr++; words_left--; words_total++;
            end
        end else if (rd_req) begin
            if (!hold_gnt) begin
                if (wait_cnt == gnt_delay) begin
                    rd_gnt = 1; data_addr = rd_addr; words_left = BURST; wait_cnt = 0;
                end else wait_cnt++;
            end
        end else wait_cnt = 0;
    end

    // Monitor: pops an expectation whenever the DUT presents an event.
    logic [23:0] ea;
    logic [15:0] ep;
    initial forever begin
        @(negedge clk_pix);
        if (rd_req && rd_gnt) begin
            vectors++;
            if (exp_addr.size() == 0) begin
                miscompares++; $display("FAIL grant_addr: got %0d, none expected", rd_addr);
            end else begin
                ea = exp_addr.pop_front();
                if (rd_addr !== ea) begin
                    miscompares++; $display("FAIL grant_addr: got %0d, expected %0d", rd_addr, ea);
                end
            end
        end
        if (pix_de === 1'b1) begin
            vectors++;
            if (exp_pix.size() == 0) begin
                miscompares++; $display("FAIL pix_data: got %0d, none expected", pix_data);
            end else begin
                ep = exp_pix.pop_front();
                if (pix_data !== ep) begin
                    miscompares++; $display("FAIL pix_data: got %0d, expected %0d", pix_data, ep);
                end
            end
        end else if (!rst) begin
            vectors++;
            if (pix_data !== 16'd0) begin
                miscompares++; $display("FAIL pix_idle: got %0d, expected 0", pix_data);
            end
        end
        if (underrun !== 1'b0 && !rst) begin
            vectors++;
            if (exp_und.size() == 0) begin
                miscompares++; $display("FAIL underrun: got %b, expected 0", underrun);
            end else void'(exp_und.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_pix); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++; $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_rd_req"}, 32'(rd_req), 0);
        chk({nm, "_rd_addr"}, 32'(rd_addr), 0);
        chk({nm, "_pix_de"}, 32'(pix_de), 0);
        chk({nm, "_pix_data"}, 32'(pix_data), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_underrun"}, 32'(underrun), 0);
    endtask

    task automatic push_line_addrs(input int base);
        for (int b = 0; b < H / BURST; b++) exp_addr.push_back(24'(base + b * BURST));
    endtask

    task automatic pulse_frame();
        tick(); frame = 1;
        tick(); frame = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (3) @(negedge clk_pix);
        while (busy && n < 3000) begin @(negedge clk_pix); n++; end
        chk(nm, 32'(busy), 0);
    endtask

    // One active line of 640 pixels followed by 400 blank cycles.
    task automatic show_line(input int syv, input int base, input bit pulse, input bit und);
        for (int x = 0; x < H; x++) begin
            tick();
            sx = 16'(x); sy = 16'(syv); de = 1; line_m = (x == 0) && pulse;
            if (x == 0 && und) exp_und.push_back(1'b1);
            exp_pix.push_back(16'(base + x));
        end
        tick(); de = 0; line_m = 0; sx = 16'(H);
        repeat (400) tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        @(negedge clk_pix);
        chk_reset_state("reset");
        tick(); rst_m = 0; en = 1;

        // Frame fetch of line 0
        push_line_addrs(0); pulse_frame(); wait_idle("frame_fetch_done");
        chk("words_line0", 32'(words_total), 640);

        // Display line 0 while fetching line 1, then line 1 while fetching line 2
        push_line_addrs(640);  show_line(0, 0, 1, 0);   wait_idle("line1_fetch_done");
        push_line_addrs(1280); show_line(1, 640, 1, 0); wait_idle("line2_fetch_done");

        // Last visible line: no fetch
        tick(); sy = 16'sd479; line_m = 1;
        tick(); line_m = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_pix);
            chk("last_line_rd_req", 32'(rd_req), 0);
            chk("last_line_busy", 32'(busy), 0);
        end
        push_line_addrs(0); pulse_frame(); wait_idle("refetch_done");

        // Grant withheld for a line: underrun and reload to line 2 base
        hold_gnt = 1;
        show_line(0, 0, 1, 0);
        show_line(1, 640, 1, 1);
        push_line_addrs(1280); hold_gnt = 0; wait_idle("reload_fetch_done");

        // Trigger coincident with the final word of a line fetch
        tick(); sy = 0;
        fire_on_last = 1; push_line_addrs(0); push_line_addrs(640); pulse_frame();
        n = 0;
        while (!fired && n < 2000) begin @(negedge clk_pix); n++; end
        chk("last_word_trigger_seen", 32'(fired), 1);
        chk("last_word_underrun", 32'(underrun), 0);
        @(negedge clk_pix);
        chk("last_word_rd_req", 32'(rd_req), 1);
        chk("last_word_rd_addr", 32'(rd_addr), 640);
        wait_idle("last_word_fetch_done");

        // Reset mid-burst with stray data afterwards
        rst_on_word = 1; exp_addr.push_back(24'd0); pulse_frame();
        n = 0;
        while (!rst_fired && n < 200) begin @(negedge clk_pix); n++; end
        chk("mid_rst_seen", 32'(rst_fired), 1);
        @(negedge clk_pix);
        chk_reset_state("mid_rst");
        repeat (10) tick();
        en = 0;
        show_line(0, 0, 1, 0);
        chk("en_off_busy", 32'(busy), 0);

        chk("addr_queue_left", 32'(exp_addr.size()), 0);
        chk("pix_queue_left", 32'(exp_pix.size()), 0);
        chk("und_queue_left", 32'(exp_und.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
